// File: rtl/mem_handshake_responder.sv
// -----------------------------------------------------------------------------
// mem_handshake_responder
//
// Memory-side responder for the MOV / RW / MOC four-phase handshake. Holds a
// byte-addressed, big-endian store of 2^ADDR_W bytes (array Mem) and serves
// byte, halfword and word reads/writes selected by the MIPS load/store opcode.
// Each access completes WAIT_CYCLES+1 clock edges after the request is sampled.
//
// Parameters
//   WAIT_CYCLES  wait states between request acceptance and completion (0..15)
//   ADDR_W       byte-address width, depth = 2^ADDR_W bytes
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   MOV        in   memory operation valid, held high until MOC is seen
//   RW         in   1 = read, 0 = write
//   Address    in   byte address
//   DataIn     in   write data, right-justified for byte/halfword stores
//   OpC        in   opcode selecting access size and sign extension
//   DataOut    out  read data (0 after a write), registered
//   MOC        out  memory operation complete, registered
//   ALIGN_ERR  out  misaligned-access flag, valid together with MOC
//
// Build option
//   MEM_ALIGN_CHECK_EN  when defined, misaligned halfword/word accesses are
//                       rejected: no write, DataOut = 0, ALIGN_ERR = 1.
//                       When undefined, ALIGN_ERR is 0 and misaligned accesses
//                       simply wrap byte by byte.
// -----------------------------------------------------------------------------
module mem_handshake_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MOV,
  input  logic              RW,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  input  logic [5:0]        OpC,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              ALIGN_ERR
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  // Opcodes that pick a non-word size. lw, sw and every unlisted opcode
  // (instruction fetch included) fall through to a word access.
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  logic [7:0] Mem [0:DEPTH-1];

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [5:0]        opc_q;
  logic [31:0]       wdata_q;

  size_t             size_q;
  logic              sgn_q;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [31:0]       rd_data;
  logic              complete;
  logic              misaligned;

  // ---------------------------------------------------------------------------
  // Opcode decode and read-data extension
  // ---------------------------------------------------------------------------
  function automatic size_t op_size(input logic [5:0] op);
    size_t sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // Only the two load opcodes sign-extend; a store opcode used for a read
  // returns its size zero-extended.
  function automatic logic op_signed(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic logic [31:0] read_extend(
    input logic [7:0] b0,
    input logic [7:0] b1,
    input logic [7:0] b2,
    input logic [7:0] b3,
    input size_t      sz,
    input logic       sgn
  );
    logic signed [7:0]  s8;
    logic signed [15:0] s16;
    logic signed [31:0] s32;
    logic        [31:0] r;
    s8  = signed'(b0);
    s16 = signed'({b0, b1});
    case (sz)
      SZ_BYTE: begin
        if (sgn) begin
          s32 = 32'(s8);
          r   = s32;
        end else begin
          r = {24'd0, b0};
        end
      end
      SZ_HALF: begin
        if (sgn) begin
          s32 = 32'(s16);
          r   = s32;
        end else begin
          r = {16'd0, b0, b1};
        end
      end
      default: r = {b0, b1, b2, b3};
    endcase
    return r;
  endfunction

  assign size_q = op_size(opc_q);
  assign sgn_q  = op_signed(opc_q);

  // Big-endian byte lanes; the ADDR_W-bit additions wrap modulo the depth.
  assign a0 = addr_q;
  assign a1 = addr_q + ADDR_ONE;
  assign a2 = addr_q + ADDR_ONE + ADDR_ONE;
  assign a3 = addr_q + ADDR_ONE + ADDR_ONE + ADDR_ONE;

  assign rd_data = read_extend(Mem[a0], Mem[a1], Mem[a2], Mem[a3], size_q, sgn_q);

  // The access happens on the edge where the wait counter has already run
  // down to zero, giving WAIT_CYCLES+1 edges from request to MOC.
  assign complete = (state_q == WAIT) && (cnt_q == 4'd0);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((size_q == SZ_HALF) && addr_q[0]) ||
                      ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Request capture: inputs are latched once in IDLE and ignored afterwards
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && MOV) begin
      addr_q  <= Address;
      rw_q    <= RW;
      opc_q   <= OpC;
      wdata_q <= DataIn;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM with registered MOC / DataOut
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      MOC     <= 1'b0;
      DataOut <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MOV) begin
            cnt_q   <= CNT_INIT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            MOC     <= 1'b1;
            DataOut <= (rw_q && !misaligned) ? rd_data : 32'd0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          // Four-phase: stay complete until the initiator withdraws MOV.
          if (!MOV) begin
            MOC     <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage write port. Reset is not applied: the array keeps its contents,
  // and a reset during WAIT never reaches the completing edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (complete && !rw_q && !misaligned) begin
      case (size_q)
        SZ_BYTE: begin
          Mem[a0] <= wdata_q[7:0];
        end
        SZ_HALF: begin
          Mem[a0] <= wdata_q[15:8];
          Mem[a1] <= wdata_q[7:0];
        end
        default: begin
          Mem[a0] <= wdata_q[31:24];
          Mem[a1] <= wdata_q[23:16];
          Mem[a2] <= wdata_q[15:8];
          Mem[a3] <= wdata_q[7:0];
        end
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // ALIGN_ERR rises and falls in step with MOC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALIGN_ERR <= 1'b0;
    end else if (complete) begin
      ALIGN_ERR <= misaligned;
    end else if ((state_q == DONE) && !MOV) begin
      ALIGN_ERR <= 1'b0;
    end
  end
`else
  assign ALIGN_ERR = 1'b0;
`endif

endmodule
